// File: rtl/spi_master_multimode.sv
// Full-duplex SPI master: val/rdy transmit word in, received word out, four CPOL/CPHA
// modes, programmable half-period divider and packet length of 1..nbits bits.
module spi_master_multimode #(
   parameter int nbits = 34,
   parameter int ncs   = 4,
   parameter int divw  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [ncs-1:0]           cs,
   output logic                     sclk,
   output logic                     mosi,
   input  logic                     miso,
   input  logic                     recv_val,
   output logic                     recv_rdy,
   input  logic [nbits-1:0]         recv_msg,
   output logic                     send_val,
   input  logic                     send_rdy,
   output logic [nbits-1:0]         send_msg,
   input  logic                     packet_size_ifc_val,
   output logic                     packet_size_ifc_rdy,
   input  logic [$clog2(nbits)-1:0] packet_size_ifc_msg,
   input  logic                     cs_addr_ifc_val,
   output logic                     cs_addr_ifc_rdy,
   input  logic [$clog2(ncs)-1:0]   cs_addr_ifc_msg,
   input  logic                     mode_ifc_val,
   output logic                     mode_ifc_rdy,
   input  logic [1:0]               mode_ifc_msg,
   input  logic                     clkdiv_ifc_val,
   output logic                     clkdiv_ifc_rdy,
   input  logic [divw-1:0]          clkdiv_ifc_msg
);

   localparam int NW  = $clog2(nbits + 1);
   localparam int HPW = NW + 1;
   localparam int CSW = $clog2(ncs);

   typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, DONE} state_t;

   state_t           state_q, state_d;
   logic [divw-1:0]  cnt_q, cnt_d;
   logic [HPW-1:0]   hp_q, hp_d;
   logic [NW-1:0]    n_q, n_d;
   logic [CSW-1:0]   cs_addr_q, cs_addr_d;
   logic [1:0]       mode_q, mode_d;
   logic [divw-1:0]  div_q, div_d;
   logic [ncs-1:0]   cs_q, cs_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic [nbits-1:0] tx_q, tx_d;
   logic [nbits-1:0] rx_q, rx_d;

   logic             in_idle;
   logic             cfg_val_any;
   logic             recv_fire;
   logic             half_done;
   logic [HPW-1:0]   hp_end;
   logic [HPW-1:0]   edge_k;
   logic             edge_go;
   logic             leading;
   logic             sample_edge;
   logic             drive_edge;
   logic [NW-1:0]    msb_idx;
   logic [NW-1:0]    n_norm;
   logic [ncs-1:0]   cs_sel;

   // Half-period k of XFER begins with an sclk edge; even k are leading edges.
   always_comb begin
      in_idle     = (state_q == IDLE);
      cfg_val_any = packet_size_ifc_val || cs_addr_ifc_val || mode_ifc_val || clkdiv_ifc_val;
      recv_fire   = recv_val && in_idle && !cfg_val_any;
      half_done   = (cnt_q == div_q);
      hp_end      = {n_q, 1'b0} - HPW'(1);
      msb_idx     = n_q - NW'(1);
      edge_go     = half_done && ((state_q == CS_SETUP) ||
                                  ((state_q == XFER) && (hp_q != hp_end)));
      edge_k      = (state_q == XFER) ? hp_q + HPW'(1) : '0;
      leading     = ~edge_k[0];
      sample_edge = edge_go && (leading ^ mode_q[0]);
      drive_edge  = edge_go && !(leading ^ mode_q[0]) && (edge_k != hp_end);

      for (int i = 0; i < ncs; i++) begin
         cs_sel[i] = (int'(cs_addr_q) != i);
      end

      if ((packet_size_ifc_msg == '0) || (int'(packet_size_ifc_msg) > nbits)) begin
         n_norm = NW'(nbits);
      end else begin
         n_norm = NW'(packet_size_ifc_msg);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hp_d      = hp_q;
      n_d       = n_q;
      cs_addr_d = cs_addr_q;
      mode_d    = mode_q;
      div_d     = div_q;
      cs_d      = cs_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      tx_d      = tx_q;
      rx_d      = rx_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (packet_size_ifc_val) n_d       = n_norm;
            if (cs_addr_ifc_val)     cs_addr_d = cs_addr_ifc_msg;
            if (mode_ifc_val)        mode_d    = mode_ifc_msg;
            if (clkdiv_ifc_val)      div_d     = clkdiv_ifc_msg;
            sclk_d = mode_d[1];
            if (recv_fire) begin
               state_d = CS_SETUP;
               cs_d    = cs_sel;
               rx_d    = '0;
               // CPHA=0 needs the first bit on the wire before the first leading edge.
               if (!mode_q[0]) begin
                  mosi_d = recv_msg[msb_idx];
                  tx_d   = recv_msg << 1;
               end else begin
                  tx_d   = recv_msg;
               end
            end
         end
         CS_SETUP: begin
            if (half_done) begin
               state_d = XFER;
               cnt_d   = '0;
               hp_d    = '0;
            end else begin
               cnt_d = cnt_q + divw'(1);
            end
         end
         XFER: begin
            if (half_done) begin
               cnt_d = '0;
               if (hp_q == hp_end) begin
                  state_d = CS_HOLD;
               end else begin
                  hp_d = hp_q + HPW'(1);
               end
            end else begin
               cnt_d = cnt_q + divw'(1);
            end
         end
         CS_HOLD: begin
            if (half_done) begin
               state_d = DONE;
               cnt_d   = '0;
               cs_d    = '1;
            end else begin
               cnt_d = cnt_q + divw'(1);
            end
         end
         DONE: begin
            sclk_d = mode_q[1];
            if (send_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (edge_go) begin
         sclk_d = leading ? ~mode_q[1] : mode_q[1];
      end
      if (sample_edge) begin
         rx_d = {rx_q[nbits-2:0], miso};
      end
      if (drive_edge) begin
         mosi_d = tx_q[msb_idx];
         tx_d   = tx_q << 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hp_q      <= '0;
         n_q       <= NW'(nbits);
         cs_addr_q <= '0;
         mode_q    <= '0;
         div_q     <= '0;
         cs_q      <= '1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hp_q      <= hp_d;
         n_q       <= n_d;
         cs_addr_q <= cs_addr_d;
         mode_q    <= mode_d;
         div_q     <= div_d;
         cs_q      <= cs_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
      end
   end

   // Shift registers carry data only; send_msg is gated by DONE so they need no reset.
   always_ff @(posedge clk) begin
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   assign cs                  = cs_q;
   assign sclk                = sclk_q;
   assign mosi                = mosi_q;
   assign send_val            = (state_q == DONE);
   assign send_msg            = send_val ? rx_q : '0;
   assign recv_rdy            = in_idle && !cfg_val_any;
   assign packet_size_ifc_rdy = in_idle;
   assign cs_addr_ifc_rdy     = in_idle;
   assign mode_ifc_rdy        = in_idle;
   assign clkdiv_ifc_rdy      = in_idle;

endmodule

// File: tb/tb_spi_master_multimode.sv
// Directed and randomized transfers against a behavioural SPI slave and a
// transfer-level model of timing, chip select and data.
module tb_spi_master_multimode;

   localparam int NB  = 34;
   localparam int NCS = 4;
   localparam int DW  = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [NCS-1:0]  cs;
   logic            sclk, mosi, miso;
   logic            recv_val, recv_rdy;
   logic [NB-1:0]   recv_msg;
   logic            send_val, send_rdy;
   logic [NB-1:0]   send_msg;
   logic            packet_size_ifc_val, packet_size_ifc_rdy;
   logic [5:0]      packet_size_ifc_msg;
   logic            cs_addr_ifc_val, cs_addr_ifc_rdy;
   logic [1:0]      cs_addr_ifc_msg;
   logic            mode_ifc_val, mode_ifc_rdy;
   logic [1:0]      mode_ifc_msg;
   logic            clkdiv_ifc_val, clkdiv_ifc_rdy;
   logic [DW-1:0]   clkdiv_ifc_msg;

   always #5 clk = ~clk;

   spi_master_multimode #(.nbits(NB), .ncs(NCS), .divw(DW)) dut (
      .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
      .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
      .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
      .packet_size_ifc_val(packet_size_ifc_val), .packet_size_ifc_rdy(packet_size_ifc_rdy),
      .packet_size_ifc_msg(packet_size_ifc_msg),
      .cs_addr_ifc_val(cs_addr_ifc_val), .cs_addr_ifc_rdy(cs_addr_ifc_rdy),
      .cs_addr_ifc_msg(cs_addr_ifc_msg),
      .mode_ifc_val(mode_ifc_val), .mode_ifc_rdy(mode_ifc_rdy), .mode_ifc_msg(mode_ifc_msg),
      .clkdiv_ifc_val(clkdiv_ifc_val), .clkdiv_ifc_rdy(clkdiv_ifc_rdy),
      .clkdiv_ifc_msg(clkdiv_ifc_msg)
   );

   int errors = 0;
   int checks = 0;

   // Reference configuration as the spec defines it
   int        m_n;
   int        m_addr;
   int        m_div;
   logic [1:0] m_mode;

   // Behavioural slave state
   logic [NB-1:0] slv_s;
   bit            slv_echo;
   int            slv_d;
   bit            active;
   int            lead_cnt;
   logic [NB-1:0] cap;
   int            pos;
   bit            lead_e;

   always_comb begin
      pos  = 0;
      miso = 1'b0;
      if (slv_echo) begin
         miso = mosi;
      end else begin
         pos = m_mode[0] ? (m_n - slv_d) : (m_n - 1 - slv_d);
         if (m_mode[0] && slv_d == 0) pos = -1;
         if (pos >= 0 && pos < m_n) miso = slv_s[pos];
      end
   end

   always @(sclk) begin
      if (active && cs !== 4'hF) begin
         lead_e = (sclk !== m_mode[1]);
         if (lead_e) lead_cnt++;
         if (lead_e ^ m_mode[0]) cap = {cap[NB-2:0], mosi};
         else slv_d++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_n = NB; m_addr = 0; m_mode = 2'b00; m_div = 0;
   endtask

   task automatic cfg_all(input logic [5:0] ps, input logic [1:0] addr,
                          input logic [1:0] md, input logic [7:0] dv);
      packet_size_ifc_val = 1'b1; packet_size_ifc_msg = ps;
      cs_addr_ifc_val     = 1'b1; cs_addr_ifc_msg     = addr;
      mode_ifc_val        = 1'b1; mode_ifc_msg        = md;
      clkdiv_ifc_val      = 1'b1; clkdiv_ifc_msg      = dv;
      @(negedge clk);
      chk("cfg_rdy", 64'({packet_size_ifc_rdy, cs_addr_ifc_rdy, mode_ifc_rdy, clkdiv_ifc_rdy}),
          64'h0F);
      @(posedge clk); #1;
      packet_size_ifc_val = 1'b0; cs_addr_ifc_val = 1'b0;
      mode_ifc_val = 1'b0; clkdiv_ifc_val = 1'b0;
      m_n    = (ps == 0 || int'(ps) > NB) ? NB : int'(ps);
      m_addr = int'(addr);
      m_mode = md;
      m_div  = int'(dv);
      @(negedge clk);
      chk("cpol_idle", 64'(sclk), 64'(md[1]));
      @(posedge clk); #1;
   endtask

   task automatic xfer(input string tag, input logic [NB-1:0] tx, input logic [NB-1:0] s,
                       input bit echo, input int stall);
      int h, exp_lat, c, cs_low;
      bit ok, got;
      logic [63:0] mask, exp_rx;
      logic [3:0]  exp_cs;
      h       = m_div + 1;
      exp_lat = (2 * m_n + 2) * h + 1;
      mask    = (64'd1 << m_n) - 64'd1;
      exp_cs  = ~(4'b0001 << m_addr);
      exp_rx  = echo ? (64'(tx) & mask) : (64'(s) & mask);
      slv_s = s; slv_echo = echo; slv_d = 0; lead_cnt = 0; cap = '0; active = 1'b1;
      recv_msg = tx; recv_val = 1'b1; ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk); ok = recv_rdy;
         @(posedge clk); #1;
      end
      recv_val = 1'b0;
      chk({tag, "_accept"}, 64'(ok), 64'd1);
      c = 0; got = 1'b0; cs_low = 0;
      while (!got && c < 8000) begin
         @(negedge clk); c++;
         if (send_val) got = 1'b1;
         else if (cs === exp_cs) cs_low++;
      end
      chk({tag, "_latency"}, got ? 64'(c) : 64'd0, 64'(exp_lat));
      chk({tag, "_cs_low"}, 64'(cs_low), 64'((2 * m_n + 2) * h));
      chk({tag, "_sclk_pulses"}, 64'(lead_cnt), 64'(m_n));
      chk({tag, "_mosi_bits"}, 64'(cap), 64'(tx) & mask);
      chk({tag, "_send_msg"}, 64'(send_msg), exp_rx);
      chk({tag, "_cs_done"}, 64'(cs), 64'h0F);
      active = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); @(negedge clk);
         chk({tag, "_stall_val"}, 64'(send_val), 64'd1);
         chk({tag, "_stall_msg"}, 64'(send_msg), exp_rx);
         chk({tag, "_stall_recv_rdy"}, 64'(recv_rdy), 64'd0);
         chk({tag, "_stall_cs"}, 64'(cs), 64'h0F);
         chk({tag, "_stall_sclk"}, 64'(sclk), 64'(m_mode[1]));
      end
      @(posedge clk); #1; send_rdy = 1'b1;
      @(posedge clk); #1; send_rdy = 1'b0;
      @(negedge clk);
      chk({tag, "_send_val_clr"}, 64'(send_val), 64'd0);
      chk({tag, "_recv_rdy_back"}, 64'(recv_rdy), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]   r64;
      logic [NB-1:0] t, s;
      bit            seen;
      reset = 1'b1; recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0;
      packet_size_ifc_val = 1'b0; packet_size_ifc_msg = '0;
      cs_addr_ifc_val = 1'b0; cs_addr_ifc_msg = '0;
      mode_ifc_val = 1'b0; mode_ifc_msg = '0;
      clkdiv_ifc_val = 1'b0; clkdiv_ifc_msg = '0;
      slv_s = '0; slv_echo = 1'b0; slv_d = 0; active = 1'b0; lead_cnt = 0; cap = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cs", 64'(cs), 64'h0F);
      chk("rst_sclk", 64'(sclk), 64'd0);
      chk("rst_mosi", 64'(mosi), 64'd0);
      chk("rst_send_val", 64'(send_val), 64'd0);
      chk("rst_send_msg", 64'(send_msg), 64'd0);
      chk("rst_recv_rdy", 64'(recv_rdy), 64'd1);
      chk("rst_cfg_rdy", 64'({packet_size_ifc_rdy, cs_addr_ifc_rdy, mode_ifc_rdy, clkdiv_ifc_rdy}),
          64'h0F);
      @(posedge clk); #1;

      // Default configuration: mode 0, D=0, N=34, echo slave
      xfer("mode0", 34'h2_DEAD_BEEF, '0, 1'b1, 0);

      cfg_all(6'd8, 2'd2, 2'b11, 8'd3);
      xfer("mode3", 34'h0_0000_00A5, 34'h0_0000_003C, 1'b0, 0);

      cfg_all(6'd4, 2'd0, 2'b01, 8'd0);
      xfer("mode1", 34'h9, '0, 1'b1, 0);
      cfg_all(6'd4, 2'd1, 2'b10, 8'd1);
      xfer("mode2", 34'h9, '0, 1'b1, 0);

      // Config and data offered together: config wins, transfer uses new N
      packet_size_ifc_msg = 6'd8; packet_size_ifc_val = 1'b1;
      recv_msg = 34'h3_0000_00C6; recv_val = 1'b1;
      @(negedge clk);
      chk("same_recv_rdy", 64'(recv_rdy), 64'd0);
      @(posedge clk); #1;
      packet_size_ifc_val = 1'b0;
      m_n = 8;
      xfer("same", 34'h3_0000_00C6, '0, 1'b1, 0);

      cfg_all(6'd0, 2'd3, 2'b00, 8'd0);
      xfer("ps0", 34'h1_2345_6789, 34'h2_A5A5_5A5A, 1'b0, 0);
      cfg_all(6'd63, 2'd0, 2'b01, 8'd0);
      xfer("ps63", 34'h3_FFFF_0000, 34'h0_F0F0_F0F1, 1'b0, 0);

      cfg_all(6'd8, 2'd1, 2'b00, 8'd0);
      xfer("stall", 34'h5A, 34'hC3, 1'b0, 10);

      cfg_all(6'd1, 2'd3, 2'b10, 8'd255);
      xfer("dmax", 34'h1, 34'h1, 1'b0, 0);

      for (int i = 0; i < 6; i++) begin
         cfg_all(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
         r64 = {$urandom, $urandom}; t = r64[NB-1:0];
         r64 = {$urandom, $urandom}; s = r64[NB-1:0];
         xfer($sformatf("rnd%0d", i), t, s, 1'($urandom_range(0, 1)), 0);
      end

      // Reset in the middle of XFER
      cfg_all(6'd0, 2'd1, 2'b11, 8'd1);
      recv_msg = 34'h3_FFFF_FFFF; recv_val = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk); seen = recv_rdy;
         @(posedge clk); #1;
      end
      recv_val = 1'b0;
      chk("mid_accept", 64'(seen), 64'd1);
      repeat (20) @(negedge clk);
      chk("mid_cs", 64'(cs), 64'h0D);
      chk("mid_mosi", 64'(mosi), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_cs", 64'(cs), 64'h0F);
      chk("mid_rst_sclk", 64'(sclk), 64'd0);
      chk("mid_rst_mosi", 64'(mosi), 64'd0);
      chk("mid_rst_send_val", 64'(send_val), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (send_val) seen = 1'b1;
      end
      chk("mid_no_send_val", 64'(seen), 64'd0);
      @(posedge clk); #1;
      xfer("fresh", 34'h1_0F0F_3C3C, '0, 1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
